// File: rtl/bcd_conv_ctrl.sv
// bcd_conv_ctrl
//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble). One
//   input bit is consumed per clock. The registered result is presented
//   together with a one-cycle done pulse.
//
//   Ports:
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset
//     start    conversion request, accepted only while idle
//     binario  binary value, captured on the accepting edge
//     busy     high while a conversion is in progress (SHIFT or FIN)
//     done     one-cycle pulse when bcd carries a new result
//     bcd      result, digit i in bits [4i+3:4i] (digit 0 = units)
//     blank    (only with BCD_CONV_BLANK_EN) leading-zero blanking flags
//
//   Optional feature macro: BCD_CONV_BLANK_EN
module bcd_conv_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binario,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_CONV_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t          state_q;
  logic [WIDTH-1:0] shift_q;
  logic [SW-1:0]   scratch_q;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   bcd_q;
  logic            done_q;
  logic [SW-1:0]   adj_d;

  // Add 3 to every 4-bit digit that is 5 or more, so the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_CONV_BLANK_EN
  // Digit i (i>=1) is blanked when it and every digit above it are zero.
  function automatic logic [DIGITS-1:0] blank_of(input logic [SW-1:0] s);
    logic [DIGITS-1:0] b;
    logic              z;
    b = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z & (s[4*i +: 4] == 4'd0);
      b[i] = z;
    end
    return b;
  endfunction

  logic [DIGITS-1:0] blank_q;
`endif

  always_comb adj_d = add3(scratch_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
`ifdef BCD_CONV_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= binario;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjusted scratch and shift register shift left as one word; the
          // scratch MSB falls off the top.
          {scratch_q, shift_q} <= {adj_d[SW-2:0], shift_q, 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIN;
        end
        FIN: begin
          bcd_q   <= scratch_q;
          done_q  <= 1'b1;
`ifdef BCD_CONV_BLANK_EN
          blank_q <= blank_of(scratch_q);
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BCD_CONV_BLANK_EN
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
module tb_bcd_conv_ctrl;

  localparam int W = 8;
  localparam int D = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     binario;
  logic             busy;
  logic             done;
  logic [4*D-1:0]   bcd;
`ifdef BCD_CONV_BLANK_EN
  logic [D-1:0]     blank;
`endif

  bcd_conv_ctrl #(.WIDTH(W), .DIGITS(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .binario (binario),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
`ifdef BCD_CONV_BLANK_EN
    ,
    .blank   (blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [4*D-1:0] bcd;
    logic [D-1:0]   blank;
  } exp_t;

  exp_t           q[$];
  int             errors = 0;
  int             checks = 0;
  int             edge_n = 0;
  int             busy_until = 0;
  int             free_at = 0;
  int             acc_cnt = 0;
  logic [4*D-1:0] last_bcd = '0;
  logic [D-1:0]   last_blank = '0;

  // Reference: decimal digits by division, blanking by magnitude.
  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] ref_blank(input int v);
    logic [D-1:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 1; i < D; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Model: decides acceptance on each rising edge from the requests seen.
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (rst_n && start && edge_n >= free_at) begin
      exp_t e;
      e.due   = edge_n + W + 1;
      e.bcd   = ref_bcd(int'(binario));
      e.blank = ref_blank(int'(binario));
      q.push_back(e);
      busy_until = edge_n + W + 1;
      free_at    = edge_n + W + 2;
      acc_cnt++;
    end
  end

  // Monitor: samples on the falling edge and checks against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
`ifdef BCD_CONV_BLANK_EN
      chk("rst_blank", 32'(blank), 32'd0);
`endif
    end else begin
      chk("busy", 32'(busy), 32'(edge_n < busy_until));
      if (q.size() > 0 && q[0].due == edge_n) begin
        exp_t e;
        e = q.pop_front();
        chk("done_at_due", 32'(done), 32'd1);
        last_bcd   = e.bcd;
        last_blank = e.blank;
      end else begin
        chk("done_idle", 32'(done), 32'd0);
      end
      chk("bcd", 32'(bcd), 32'(last_bcd));
`ifdef BCD_CONV_BLANK_EN
      chk("blank", 32'(blank), 32'(last_blank));
`endif
    end
  end

  task automatic step(input logic st, input logic [W-1:0] v);
    start   = st;
    binario = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, binario);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    last_bcd   = '0;
    last_blank = '0;
    busy_until = 0;
    free_at    = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    start   = 1'b0;
    binario = '0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Full-scale and zero inputs.
    step(1'b1, 8'd255);
    idle(12);
    step(1'b1, 8'd0);
    idle(12);

    // Back-to-back: request held through the busy window is taken in the done cycle.
    step(1'b1, 8'd99);
    for (int i = 0; i < 10; i++) step(1'b1, 8'd100);
    idle(12);

    // Request mid-conversion is ignored.
    step(1'b1, 8'd128);
    idle(2);
    step(1'b1, 8'd7);
    idle(12);

    // Reset in the middle of a conversion, then a clean conversion.
    step(1'b1, 8'd200);
    idle(4);
    do_reset();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    step(1'b1, 8'd47);
    idle(12);

    // Full sweep, each value taken as soon as the converter frees up.
    for (int v = 0; v < 256; v++) begin
      int a0;
      int guard;
      a0 = acc_cnt;
      guard = 0;
      start = 1'b1;
      binario = W'(v);
      while (acc_cnt == a0 && guard < 30) begin
        @(posedge clk);
        #1;
        guard++;
      end
      chk("sweep_accept", 32'(acc_cnt - a0), 32'd1);
    end
    idle(12);

    // Random requests and input churn during conversions.
    for (int i = 0; i < 600; i++) step(($urandom % 4) == 0, W'($urandom));
    idle(15);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
